// File: rtl/ospfb_run_ctrl_pkg.sv
// Shared types for the OSPFB run-control sequencer: state encoding and
// fault_cause bit positions.
package ospfb_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FLUSH = 3'd1,
      ST_FILL  = 3'd2,
      ST_RUN   = 3'd3,
      ST_FAULT = 3'd4
   } ospfb_run_state_t;

   localparam int CAUSE_W           = 5;
   localparam int CAUSE_TLAST_UNEXP = 0;
   localparam int CAUSE_TLAST_MISS  = 1;
   localparam int CAUSE_CHAN_HALT   = 2;
   localparam int CAUSE_FILL_TMO    = 3;
   localparam int CAUSE_RSVD        = 4;

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter: counts inc strobes, sticks at all-ones,
// cleared by rst or clr (clr wins over a coincident inc).
module sat_event_counter #(
   parameter int CNT_WID = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               clr,
   output logic [CNT_WID-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + CNT_WID'(1);
   end

endmodule

// File: rtl/ospfb_run_ctrl.sv
// Run-control sequencer for the OSPFB datapath: flush, pre-fill, run, and
// latch fatal FFT events as faults while counting frame/overflow strobes.
module ospfb_run_ctrl
   import ospfb_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH       = 512,
   parameter int DATA_COUNT_WIDTH = $clog2(FIFO_DEPTH),
   parameter int FILL_THRESH      = FIFO_DEPTH/2,
   parameter int RST_CYCLES       = 16,
   parameter int FILL_TIMEOUT     = 65535,
   parameter int CNT_WID          = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        clear_faults,
   input  logic [DATA_COUNT_WIDTH-1:0] rd_count,
   input  logic                        event_frame_started,
   input  logic                        event_tlast_unexpected,
   input  logic                        event_tlast_missing,
   input  logic                        event_fft_overflow,
   input  logic                        event_data_in_channel_halt,
   output logic                        ospfb_rst,
   output logic                        ospfb_en,
   output logic [2:0]                  state,
   output logic                        fault,
   output logic [CAUSE_W-1:0]          fault_cause,
   output logic [CNT_WID-1:0]          frame_cnt,
   output logic [CNT_WID-1:0]          overflow_cnt
);

   localparam int FLUSH_W = $clog2(RST_CYCLES + 1);
   localparam int TMR_W   = $clog2(FILL_TIMEOUT + 1);

   ospfb_run_state_t     state_q;
   ospfb_run_state_t     state_d;
   logic [FLUSH_W-1:0]   flush_cnt_q;
   logic [TMR_W-1:0]     fill_tmr_q;
   logic [CAUSE_W-1:0]   cause_set;
   logic                 fatal_evt;
   logic                 fill_ready;
   logic                 fill_expired;
   logic                 in_run;

   assign fatal_evt    = event_tlast_unexpected | event_tlast_missing |
                         event_data_in_channel_halt;
   assign fill_ready   = {1'b0, rd_count} >= (DATA_COUNT_WIDTH+1)'(FILL_THRESH);
   assign fill_expired = (fill_tmr_q == '0);
   assign in_run       = (state_q == ST_RUN);
   assign state        = state_q;

   // Next-state: timeout/fatal beat stop, stop beats fill-ready and start.
   always_comb begin
      state_d   = state_q;
      cause_set = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (start)
               state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (stop)
               state_d = ST_IDLE;
            else if (flush_cnt_q == '0)
               state_d = ST_FILL;
         end
         ST_FILL: begin
            if (fill_expired && !fill_ready) begin
               state_d                   = ST_FAULT;
               cause_set[CAUSE_FILL_TMO] = 1'b1;
            end else if (stop)
               state_d = ST_IDLE;
            else if (fill_ready)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (fatal_evt) begin
               state_d                      = ST_FAULT;
               cause_set[CAUSE_TLAST_UNEXP] = event_tlast_unexpected;
               cause_set[CAUSE_TLAST_MISS]  = event_tlast_missing;
               cause_set[CAUSE_CHAN_HALT]   = event_data_in_channel_halt;
            end else if (stop)
               state_d = ST_IDLE;
         end
         ST_FAULT: begin
            if (clear_faults)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ospfb_rst   <= 1'b1;
         ospfb_en    <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= '0;
      end else begin
         state_q     <= state_d;
         ospfb_rst   <= (state_d == ST_IDLE) || (state_d == ST_FLUSH) ||
                        (state_d == ST_FAULT);
         ospfb_en    <= (state_d == ST_RUN);
         fault       <= (state_d == ST_FAULT);
         fault_cause <= clear_faults ? '0 : (fault_cause | cause_set);
      end
   end

   // Timers preload while outside their state, so entry always starts full.
   always_ff @(posedge clk) begin
      flush_cnt_q <= (state_q != ST_FLUSH) ? FLUSH_W'(RST_CYCLES - 1)
                                           : flush_cnt_q - FLUSH_W'(1);
      fill_tmr_q  <= (state_q != ST_FILL)  ? TMR_W'(FILL_TIMEOUT - 1)
                                           : fill_tmr_q - TMR_W'(1);
   end

   sat_event_counter #(.CNT_WID(CNT_WID)) u_frame_cnt (
      .clk (clk),
      .rst (rst),
      .inc (in_run && event_frame_started),
      .clr (clear_faults),
      .cnt (frame_cnt)
   );

   sat_event_counter #(.CNT_WID(CNT_WID)) u_overflow_cnt (
      .clk (clk),
      .rst (rst),
      .inc (in_run && event_fft_overflow),
      .clr (clear_faults),
      .cnt (overflow_cnt)
   );

endmodule
